// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: port ids, request bundle and bank helper
// shared by ram_arbiter and ram_arbiter_sel.
package ram_arbiter_pkg;

  localparam int PORT_CPU = 0;
  localparam int PORT_DMA = 1;
  localparam int ADDR_MAX = 32;

  typedef struct packed {
    logic                req;
    logic                we;
    logic [ADDR_MAX-1:0] addr;
    logic [7:0]          wdata;
  } port_req_t;

  // Even byte addresses live in bank 0, odd in bank 1.
  function automatic logic bank_of(
    input logic [ADDR_MAX-1:0] addr
  );
    return 1'(addr % 2);
  endfunction

endpackage

// File: rtl/ram_arbiter_sel.sv
// ram_arbiter_sel: grant decision for the two requesters.
// RAM_ARBITER_RR_EN selects round-robin instead of starvation-guarded priority.
module ram_arbiter_sel
  import ram_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_chk
    $error("MAX_WAIT out of range 1..255");
  end

`ifdef RAM_ARBITER_RR_EN

  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'(PORT_DMA);
    end else if (gnt0 || gnt1) begin
      last <= gnt1;
    end
  end

  // On conflict the port that did not win last time goes.
  always_comb begin
    gnt1 = rst_n && req1 && (!req0 || !last);
    gnt0 = rst_n && req0 && !gnt1;
  end

`else

  logic [7:0] wait_cnt;
  logic       starve;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!req1 || gnt1) begin
      wait_cnt <= '0;
    end else if (wait_cnt != 8'(MAX_WAIT)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  always_comb begin
    starve = req1 && (wait_cnt == 8'(MAX_WAIT));
    gnt1   = rst_n && req1 && (!req0 || starve);
    gnt0   = rst_n && req0 && !gnt1;
  end

`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the two-bank byte RAM between CPU and DMA ports.
// Define RAM_ARBITER_RR_EN for round-robin arbitration.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [7:0]        m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [7:0]        m1_rdata,
  output logic [ADDR_W-2:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_en0,
  output logic              ram_en1,
  output logic              ram_we0,
  output logic              ram_we1,
  input  logic [7:0]        ram_rdata0,
  input  logic [7:0]        ram_rdata1
);

  if (ADDR_W < 2 || ADDR_W > ADDR_MAX) begin : g_chk
    $error("ADDR_W out of range 2..32");
  end

  port_req_t  req [2];
  port_req_t  act;
  logic       sel_port;
  logic       any;
  logic       bank;
  logic [1:0] rvalid;
  logic       rbank;
  logic [7:0] bank_rdata;
  logic [7:0] hold0;
  logic [7:0] hold1;

  assign req[PORT_CPU] = '{m0_req, m0_we,
                           ADDR_MAX'(m0_addr), m0_wdata};
  assign req[PORT_DMA] = '{m1_req, m1_we,
                           ADDR_MAX'(m1_addr), m1_wdata};

  ram_arbiter_sel #(
    .MAX_WAIT(MAX_WAIT)
  ) u_sel (
    .clk  (clk),
    .rst_n(rst_n),
    .req0 (req[PORT_CPU].req),
    .req1 (req[PORT_DMA].req),
    .gnt0 (m0_gnt),
    .gnt1 (m1_gnt)
  );

  // With no grant the bus idles on the CPU port's address/data.
  assign sel_port = m1_gnt;
  assign act      = req[sel_port];

  always_comb begin
    any       = m0_gnt | m1_gnt;
    bank      = bank_of(act.addr);
    ram_en0   = any & ~bank;
    ram_en1   = any & bank;
    ram_we0   = ram_en0 & act.we;
    ram_we1   = ram_en1 & act.we;
    ram_addr  = act.addr[ADDR_W-1:1];
    ram_wdata = act.wdata;
  end

  // One grant per cycle, so one bank tag covers both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= '0;
      rbank  <= 1'b0;
    end else begin
      rvalid[0] <= m0_gnt & ~m0_we;
      rvalid[1] <= m1_gnt & ~m1_we;
      if (any) begin
        rbank <= bank;
      end
    end
  end

  assign bank_rdata = rbank ? ram_rdata1 : ram_rdata0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold0 <= '0;
      hold1 <= '0;
    end else begin
      if (rvalid[0]) begin
        hold0 <= bank_rdata;
      end
      if (rvalid[1]) begin
        hold1 <= bank_rdata;
      end
    end
  end

  assign m0_rvalid = rvalid[0];
  assign m1_rvalid = rvalid[1];
  assign m0_rdata  = rvalid[0] ? bank_rdata : hold0;
  assign m1_rdata  = rvalid[1] ? bank_rdata : hold1;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a read-data scoreboard
// and a registered two-bank RAM model.
module tb_ram_arbiter;

  logic        clk;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [15:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [7:0]  m0_rdata, m1_rdata;
  logic [14:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata0, ram_rdata1;
  logic        ram_en0, ram_en1, ram_we0, ram_we1;

  logic [7:0]  q0 [$];
  logic [7:0]  q1 [$];
  logic [7:0]  mem0 [256];
  logic [7:0]  mem1 [256];
  logic        e1;
  int          passed = 0;
  int          total  = 0;

  ram_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_en0   (ram_en0),
    .ram_en1   (ram_en1),
    .ram_we0   (ram_we0),
    .ram_we1   (ram_we1),
    .ram_rdata0(ram_rdata0),
    .ram_rdata1(ram_rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bank contents: mem0[i] = i^3C, mem1[i] = i^DA.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 256; i++) begin
        mem0[i] <= 8'(i) ^ 8'h3C;
        mem1[i] <= 8'(i) ^ 8'hDA;
      end
      ram_rdata0 <= '0;
      ram_rdata1 <= '0;
    end else begin
      if (ram_en0) begin
        if (ram_we0) mem0[ram_addr[7:0]] <= ram_wdata;
        else ram_rdata0 <= mem0[ram_addr[7:0]];
      end
      if (ram_en1) begin
        if (ram_we1) mem1[ram_addr[7:0]] <= ram_wdata;
        else ram_rdata1 <= mem1[ram_addr[7:0]];
      end
    end
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  // Monitor: every rvalid must match the oldest expected read.
  always @(negedge clk) begin
    if (m0_rvalid) begin
      if (q0.size() == 0) chk("m0_rvalid_spurious", 32'd1, 32'd0);
      else chk("m0_rdata", 32'(m0_rdata), 32'(q0.pop_front()));
    end
    if (m1_rvalid) begin
      if (q1.size() == 0) chk("m1_rvalid_spurious", 32'd1, 32'd0);
      else chk("m1_rdata", 32'(m1_rdata), 32'(q1.pop_front()));
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0;
    m0_addr = 16'h0101; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0;
    m1_addr = '0; m1_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt0", 32'(m0_gnt), 0);
    chk("rst_gnt1", 32'(m1_gnt), 0);
    chk("rst_rvalid", 32'({m1_rvalid, m0_rvalid}), 0);
    chk("rst_en", 32'({ram_en1, ram_en0}), 0);
    chk("rst_we", 32'({ram_we1, ram_we0}), 0);
    chk("rst_rdata0", 32'(m0_rdata), 0);
    chk("rst_rdata1", 32'(m1_rdata), 0);

    // m0 read of 0x0101 right after release
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rd_gnt0", 32'(m0_gnt), 1);
    chk("rd_gnt1", 32'(m1_gnt), 0);
    chk("rd_en", 32'({ram_en1, ram_en0}), 'h2);
    chk("rd_we", 32'({ram_we1, ram_we0}), 0);
    chk("rd_addr", 32'(ram_addr), 'h0080);
    q0.push_back(8'h5A);
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    chk("idle_en", 32'({ram_en1, ram_en0}), 0);

    // m1 write 0x33 to 0x0200
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b1;
    m1_addr = 16'h0200; m1_wdata = 8'h33;
    @(negedge clk);
    chk("wr_gnt1", 32'(m1_gnt), 1);
    chk("wr_gnt0", 32'(m0_gnt), 0);
    chk("wr_en", 32'({ram_en1, ram_en0}), 'h1);
    chk("wr_we", 32'({ram_we1, ram_we0}), 'h1);
    chk("wr_wdata", 32'(ram_wdata), 'h33);
    chk("wr_addr", 32'(ram_addr), 'h0100);
    @(posedge clk); #1 m1_req = 1'b0;
    @(negedge clk);
    chk("m0_rdata_hold", 32'(m0_rdata), 'h5A);

    // m1 reads the written byte back
    @(posedge clk); #1;
    m1_req = 1'b1; m1_we = 1'b0;
    @(negedge clk);
    chk("rb_gnt1", 32'(m1_gnt), 1);
    q1.push_back(8'h33);
    @(posedge clk); #1 m1_req = 1'b0;

    // back-to-back reads on both ports
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 16'h0010;
    m1_req = 1'b1; m1_addr = 16'h0011;
    @(negedge clk);
    chk("b2b_gnt0", 32'(m0_gnt), 1);
    chk("b2b_en0", 32'(ram_en0), 1);
    q0.push_back(8'h34);
    @(posedge clk); #1 m0_req = 1'b0;
    @(negedge clk);
    chk("b2b_gnt1", 32'(m1_gnt), 1);
    chk("b2b_en1", 32'(ram_en1), 1);
    q1.push_back(8'hD2);
    @(posedge clk); #1 m1_req = 1'b0;
    @(negedge clk);
    chk("b2b_hold0", 32'(m0_rdata), 'h34);

    // read granted, then reset before its rvalid
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 16'h0006;
    @(negedge clk);
    chk("rp_gnt0", 32'(m0_gnt), 1);
    @(posedge clk); #1;
    rst_n = 1'b0; m0_req = 1'b0;
    @(negedge clk);
    chk("rp_rvalid_rst", 32'(m0_rvalid), 0);
    chk("rp_rdata_rst", 32'(m0_rdata), 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rp_rvalid_after", 32'(m0_rvalid), 0);
    end

    // continuous contention on both ports
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 16'h0004;
    m1_req = 1'b1; m1_addr = 16'h0007;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
`ifdef RAM_ARBITER_RR_EN
      e1 = (k % 2) == 1;
`else
      e1 = (k % 9) == 8;
`endif
      chk($sformatf("arb_gnt1_%0d", k), 32'(m1_gnt), 32'(e1));
      chk($sformatf("arb_gnt0_%0d", k), 32'(m0_gnt), 32'(!e1));
      if (e1) q1.push_back(8'hD9);
      else q0.push_back(8'h3E);
      @(posedge clk); #1;
    end
    m0_req = 1'b0; m1_req = 1'b0;

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the two-bank 8-bit RAM (bank 0 = even addresses, bank 1 = odd addresses) between two requesters.
- Requester 0 is the 6502 core; requester 1 is a DMA/loader port (e.g. a UART boot loader).
- Accepts at most one access per cycle and steers it to the correct bank.
- Returns read data with a fixed one-cycle latency.
- Sits between the CPU/loader and the RAM bank instances inside the system top level.

Parameters:
- ADDR_W, 16, byte address width of both requester ports; each bank uses ADDR_W-1 bits.
- MAX_WAIT, 8, cycles requester 1 may be refused before it is force-granted. Legal range 1..255.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- m0_req  in  1  requester 0 access request, held until granted.
- m0_we  in  1  1 = write, 0 = read.
- m0_addr  in  ADDR_W  byte address.
- m0_wdata  in  8  write data.
- m0_gnt  out  1  access accepted this cycle.
- m0_rvalid  out  1  read data valid, one cycle after a granted read.
- m0_rdata  out  8  read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata: same as the m0_* ports, for requester 1.
- ram_addr  out  ADDR_W-1  bank word address, equal to addr[ADDR_W-1:1].
- ram_wdata  out  8  write data to both banks.
- ram_en0, ram_en1  out  1  bank enable.
- ram_we0, ram_we1  out  1  bank write enable.
- ram_rdata0, ram_rdata1  in  8  bank read data, registered by the bank with 1-cycle latency.

Behaviour:
- Reset (async assert, sync release) clears all state:
  - gnt, rvalid, ram_en*, ram_we* = 0.
  - rdata = 0.
  - wait counter = 0.
  - pending-read registers cleared.
- Arbitration is combinational from req and registered state; m*_gnt is asserted in the same cycle as the access.
- A requester keeps req/we/addr/wdata stable until it sees gnt. Dropping req before grant is legal and leaves no side effect.
- Default selection (macro absent):
  - m0 wins whenever m0_req=1, unless wait_cnt==MAX_WAIT and m1_req=1; in that case m1 wins.
  - wait_cnt increments (saturating at MAX_WAIT) on each cycle m1_req=1 and m1 is not granted.
  - wait_cnt clears when m1 is granted or when m1_req=0.
- Granted access drives the RAM in the same cycle:
  - Bank selected by addr[0]: 0 → bank 0, 1 → bank 1.
  - ram_en<bank>=1; ram_we<bank>=we.
  - ram_addr = addr[ADDR_W-1:1]; ram_wdata = wdata.
  - The other bank has en=0 and we=0.
- No grant: all ram_en*/ram_we* = 0. ram_addr and ram_wdata are don't-care but are driven from m0.
- Read return:
  - The cycle after a granted read, the owning m*_rvalid=1 for exactly one cycle.
  - m*_rdata is the registered bank-select mux of ram_rdata0/1.
  - m*_rdata holds its value until the next rvalid for that port.
- Writes never produce rvalid.
- Back-to-back grants are allowed every cycle, including a read on one port followed by an access on the other. rvalid/rdata tracking is per port and must not be overwritten by the other port's grant.
- Reset asserted between a grant and its rvalid drops the pending read: no rvalid is produced after release.
- Full-range address wrap is not required; addresses are taken modulo 2^ADDR_W.

Optional Feature:
- RAM_ARBITER_RR_EN
- Defined:
  - When both requests are active, the grant alternates using a last-winner register (reset value: m1, so m0 wins the first conflict).
  - A single requester is always granted.
  - wait_cnt and MAX_WAIT are unused; the counter logic is removed.
- Undefined: fixed priority with the starvation counter, as specified under Behaviour.

Decomposition:
- Package ram_arbiter_pkg:
  - PORT_CPU=0 and PORT_DMA=1 constants.
  - Bank-select helper function (addr → bank index).
  - Typedef for the per-port request bundle (req, we, addr, wdata).
- One sub-module, ram_arbiter_sel: the grant decision (priority/starvation or round-robin) plus its state registers.
- Bank steering and read-return tracking stay in ram_arbiter.

Test Plan:
- Reset: hold rst_n=0 while m0_req=1 → all gnt/rvalid/ram_en*/ram_we*=0. Release → m0_gnt=1 on the first active edge cycle.
- m0 read at 0x0101:
  - Cycle 0: m0_gnt=1, ram_en1=1, ram_addr=0x0080.
  - Cycle 1 (bank model returns 0x5A): m0_rvalid=1, m0_rdata=0x5A.
- m1 write 0x33 to 0x0200 with m0 idle → m1_gnt=1, ram_en0=1, ram_we0=1, ram_wdata=0x33; no rvalid follows.
- Both request continuously (macro absent, MAX_WAIT=8) → m0 granted 8 cycles, m1 granted on the 9th cycle, pattern repeats; m1 is never refused more than 8 consecutive cycles.
- Macro defined, both request continuously → grants alternate m0, m1, m0, …; rdata for each port matches the bank model across interleaved reads.
- m0 read granted, rst_n pulsed low the next cycle → after release, m0_rvalid stays 0 until a new read is granted.
